add_sub4: RTL and testbench

Registered 4-bit two's-complement adder/subtractor. A single `op` bit selects `a + b + c_in` or `a - b - c_in`. A ripple-carry datapath (B-operand XOR conditioning plus four full-adder stages) computes the result, which is captured on the clock edge. It is the arithmetic leaf used by wider datapaths and chains through `c_in`/`c_out`.

---
 rtl/add_sub4.sv | 62 ++++++
 tb/tb_add_sub4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/add_sub4.sv
// add_sub4: registered 4-bit two's-complement adder/subtractor (a+b+c_in or a-b-c_in).
// Latency 1 cycle, one result per cycle; no handshake, so every edge captures new inputs.
// No backpressure: the output register is overwritten each edge; rst clears it asynchronously.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears all outputs immediately
//   op    in   0 = add, 1 = subtract
//   a     in   [3:0] operand A, signed
//   b     in   [3:0] operand B, signed
//   c_in  in   carry-in when adding, borrow-in when subtracting
//   sum   out  [3:0] registered result, low 4 bits
//   c_out out  registered raw carry out of bit 3 (for subtract: 1 = no borrow)
//   ovf   out  registered signed-overflow flag
module add_sub4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       ovf
);

  logic [3:0] w_b_eff;
  logic [4:0] w_c;
  logic [3:0] w_s;

  logic [3:0] r_sum;
  logic       r_c_out;
  logic       r_ovf;

  // Subtraction is a + ~b + 1; the "+1" rides on the carry-in, and a borrow-in
  // removes it again, hence op ^ c_in.
  assign w_b_eff = b ^ {4{op}};
  assign w_c[0]  = op ^ c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign w_s[i]   = a[i] ^ w_b_eff[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & w_b_eff[i]) | (a[i] & w_c[i]) | (w_b_eff[i] & w_c[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 4'd0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sum   <= w_s;
      r_c_out <= w_c[4];
      // Carries into and out of the sign bit disagree exactly on signed overflow.
      r_ovf   <= w_c[4] ^ w_c[3];
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_add_sub4.sv
// tb_add_sub4: self-checking bench for add_sub4 (directed, sweep, exhaustive, random).
// Inputs are driven just after a rising edge and outputs sampled 1 time unit after the next.
// The reference model works on plain integers, independent of the carry chain.
module tb_add_sub4;

  logic       clk;
  logic       rst;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] sum;
  logic       c_out;
  logic       ovf;

  int n_tests;
  int n_fail;

  add_sub4 dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {ovf, c_out, sum}.
  function automatic logic [7:0] obs();
    return {2'b00, ovf, c_out, sum};
  endfunction

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic logic [7:0] model(logic m_op, logic [3:0] m_a, logic [3:0] m_b, logic m_ci);
    int ua, ub, ci, sa, sb, r, sr;
    logic co, ov;
    logic [3:0] s;
    ua = int'(m_a);
    ub = int'(m_b);
    ci = m_ci ? 1 : 0;
    sa = int'($signed(m_a));
    sb = int'($signed(m_b));
    if (!m_op) begin
      r  = ua + ub + ci;
      co = (r >= 16);
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      co = (r >= 0);          // no borrow
      sr = sa - sb - ci;
    end
    s  = 4'(r & 15);
    ov = (sr < -8) || (sr > 7);
    return {2'b00, ov, co, s};
  endfunction

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  // Drive inputs, wait one edge, sample just after it.
  task automatic step(input logic s_op, input logic [3:0] s_a, input logic [3:0] s_b, input logic s_ci);
    op   = s_op;
    a    = s_a;
    b    = s_b;
    c_in = s_ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_v;
    logic [4:0] golden5;
    logic [3:0] bb;
    logic       oo;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; op = 1'b0; a = 4'd0; b = 4'd0; c_in = 1'b0;

    // Reset values while held across edges.
    @(posedge clk); #1;
    chk("reset_hold", obs(), 8'b00_0_0_0000);
    rst = 1'b0;

    // Load a nonzero result, then assert reset away from any edge.
    step(1'b0, 4'd7, 4'd0, 1'b0);
    chk("pre_reset_nonzero", obs(), 8'b00_0_0_0111);
    #2 rst = 1'b1;
    #1 chk("async_reset", obs(), 8'b00_0_0_0000);
    @(posedge clk); #1;
    chk("reset_held_edge", obs(), 8'b00_0_0_0000);
    rst = 1'b0;

    step(1'b0, 4'd5, 4'd0, 1'b0);
    chk("post_reset_5", obs(), 8'b00_0_0_0101);

    // Directed cases: {ovf, c_out, sum}.
    step(1'b1, 4'd5, 4'd3, 1'b0);
    chk("sub_5_3", obs(), 8'b00_0_1_0010);
    step(1'b1, 4'd5, 4'd6, 1'b0);
    chk("sub_5_6_borrow", obs(), 8'b00_0_0_1111);
    step(1'b0, 4'd5, 4'd3, 1'b0);
    chk("add_ovf", obs(), 8'b00_1_0_1000);
    step(1'b1, 4'b1000, 4'd1, 1'b0);
    chk("sub_ovf", obs(), 8'b00_1_1_0111);
    step(1'b0, 4'd15, 4'd1, 1'b1);
    chk("add_cin", obs(), 8'b00_0_1_0001);
    step(1'b1, 4'd5, 4'd3, 1'b1);
    chk("sub_bin", obs(), 8'b00_0_1_0001);

    // Inputs changing between edges must not disturb the registered result.
    op = 1'b0; a = 4'd9; b = 4'd9; c_in = 1'b1;
    #3 chk("hold_between_edges", obs(), 8'b00_0_1_0001);
    @(posedge clk); #1;
    chk("captured_next_edge", obs(), model(1'b0, 4'd9, 4'd9, 1'b1));

    // Sweep: a=5, op toggling, b counting with wrap; check the 5-bit combined view.
    oo = 1'b0;
    bb = 4'd0;
    for (int i = 0; i < 32; i++) begin
      golden5 = oo ? 5'((21 - int'(bb)) & 31) : 5'(5 + int'(bb));
      step(oo, 4'd5, bb, 1'b0);
      chk($sformatf("sweep_%0d", i), {3'b000, c_out, sum}, {3'b000, golden5});
      oo = ~oo;
      bb = bb + 4'd1;
    end

    // Exhaustive: all op/c_in/a/b combinations, 1-cycle latency.
    for (int k = 0; k < 1024; k++) begin
      logic [9:0] v;
      v = 10'(k);
      exp_v = model(v[9], v[7:4], v[3:0], v[8]);
      step(v[9], v[7:4], v[3:0], v[8]);
      chk($sformatf("exh_op%0d_ci%0d_a%0d_b%0d", v[9], v[8], v[7:4], v[3:0]), obs(), exp_v);
    end

    // Random back-to-back operations.
    for (int k = 0; k < 300; k++) begin
      logic       r_op, r_ci;
      logic [3:0] r_a, r_b;
      r_op = 1'($urandom_range(1, 0));
      r_ci = 1'($urandom_range(1, 0));
      r_a  = 4'($urandom_range(15, 0));
      r_b  = 4'($urandom_range(15, 0));
      step(r_op, r_a, r_b, r_ci);
      chk($sformatf("rand_%0d", k), obs(), model(r_op, r_a, r_b, r_ci));
    end

    // Reset mid-stream discards the result; first output after release follows new inputs.
    op = 1'b0; a = 4'd3; b = 4'd4; c_in = 1'b0;
    #2 rst = 1'b1;
    #1 chk("midstream_reset", obs(), 8'b00_0_0_0000);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 4'd2, 4'd7, 1'b0);
    chk("after_midstream_reset", obs(), model(1'b1, 4'd2, 4'd7, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
